// File: rtl/led_matrix_scanner.sv
// Multiplexed LED matrix scanner: one row lit per time slot, double-buffered frame
// swapped only at frame boundaries, global PWM brightness, blanking at each row start.
module led_matrix_scanner #(
    parameter int ROWS           = 8,
    parameter int COLS           = 8,
    parameter int ROW_DIV        = 8333,
    parameter int BLANK          = 16,
    parameter int PWM_BITS       = 4,
    parameter int ROW_ACTIVE_LOW = 0,
    parameter int COL_ACTIVE_LOW = 1
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic [ROWS*COLS-1:0]   i_data,
    input  logic                   i_load,
    output logic                   o_load_ack,
    input  logic [PWM_BITS-1:0]    i_brightness,
    output logic [ROWS-1:0]        o_rows,
    output logic [COLS-1:0]        o_cols,
    output logic                   o_frame_start
);

    localparam int RW = $clog2(ROWS);
    localparam int SW = $clog2(ROW_DIV);

    localparam logic [RW-1:0]   ROW_LAST   = RW'(ROWS - 1);
    localparam logic [SW-1:0]   SLOT_LAST  = SW'(ROW_DIV - 1);
    localparam logic [SW-1:0]   SLOT_BLANK = SW'(BLANK);
    localparam logic [SW-1:0]   SLOT_PRE   = SW'(BLANK - 1);
    localparam logic [ROWS-1:0] ROWS_IDLE  = {ROWS{ROW_ACTIVE_LOW != 0}};
    localparam logic [COLS-1:0] COLS_IDLE  = {COLS{COL_ACTIVE_LOW != 0}};

    logic [RW-1:0]         row_q, row_d;
    logic [SW-1:0]         slot_q, slot_d;
    logic [PWM_BITS-1:0]   pwm_q, pwm_d;
    logic [PWM_BITS-1:0]   bright_q, bright_d;
    logic [ROWS*COLS-1:0]  disp_q, disp_d;
    logic [ROWS*COLS-1:0]  pend_q, pend_d;
    logic                  flag_q, flag_d;
    logic [ROWS-1:0]       rows_q, rows_d;
    logic [COLS-1:0]       cols_q, cols_d;
    logic                  ack_q, ack_d;
    logic                  frame_start_q, frame_start_d;

    logic                  row_wrap;
    logic                  frame_wrap;
    logic [ROWS-1:0]       row_onehot;
    logic [COLS-1:0]       row_pixels;

    always_comb begin
        row_wrap   = (slot_q == SLOT_LAST);
        frame_wrap = row_wrap && (row_q == ROW_LAST);

        slot_d = row_wrap ? '0 : slot_q + SW'(1);
        row_d  = row_q;
        if (row_wrap) begin
            row_d = (row_q == ROW_LAST) ? '0 : row_q + RW'(1);
        end
        // PWM phase restarts so that pwm_q is zero on the first lit cycle of every slot.
        pwm_d = (slot_q == SLOT_PRE) ? '0 : pwm_q + PWM_BITS'(1);

        disp_d   = disp_q;
        pend_d   = pend_q;
        flag_d   = flag_q;
        bright_d = bright_q;
        if (frame_wrap) begin
            bright_d = i_brightness;
            if (flag_q) begin
                disp_d = pend_q;
                flag_d = 1'b0;
            end
        end
        // A load on the boundary cycle itself is kept for the following frame.
        if (i_load) begin
            pend_d = i_data;
            flag_d = 1'b1;
        end

        row_onehot = '0;
        row_pixels = '0;
        for (int r = 0; r < ROWS; r++) begin
            if (row_q == RW'(r)) begin
                row_onehot[r] = 1'b1;
                row_pixels    = disp_q[r*COLS +: COLS];
            end
        end

        if (slot_q < SLOT_BLANK) begin
            rows_d = ROWS_IDLE;
            cols_d = COLS_IDLE;
        end else begin
            rows_d = row_onehot ^ ROWS_IDLE;
            cols_d = ((pwm_q < bright_q) ? row_pixels : '0) ^ COLS_IDLE;
        end

        ack_d         = i_load;
        frame_start_d = (row_q == '0) && (slot_q == '0);
    end

    // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            row_q         <= '0;
            slot_q        <= '0;
            pwm_q         <= '0;
            bright_q      <= '0;
            // NOTE: frame buffers are reset so a reset always restarts with a dark display.
            disp_q        <= '0;
            pend_q        <= '0;
            flag_q        <= 1'b0;
            rows_q        <= ROWS_IDLE;
            cols_q        <= COLS_IDLE;
            ack_q         <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            row_q         <= row_d;
            slot_q        <= slot_d;
            pwm_q         <= pwm_d;
            bright_q      <= bright_d;
            disp_q        <= disp_d;
            pend_q        <= pend_d;
            flag_q        <= flag_d;
            rows_q        <= rows_d;
            cols_q        <= cols_d;
            ack_q         <= ack_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign o_rows        = rows_q;
    assign o_cols        = cols_q;
    assign o_load_ack    = ack_q;
    assign o_frame_start = frame_start_q;

endmodule

// File: tb/tb_led_matrix_scanner.sv
// Directed bench for led_matrix_scanner on a 4x4 matrix, 20-cycle rows, 2 blank cycles,
// 2-bit PWM; every output is checked each cycle against hand-derived frame contents.
module tb_led_matrix_scanner;

    localparam int ROWS     = 4;
    localparam int COLS     = 4;
    localparam int ROW_DIV  = 20;
    localparam int BLANK    = 2;
    localparam int PWM_BITS = 2;
    localparam int FRAME    = ROWS * ROW_DIV;

    logic                  clk = 1'b0;
    logic                  i_reset;
    logic [ROWS*COLS-1:0]  i_data;
    logic                  i_load;
    logic                  o_load_ack;
    logic [PWM_BITS-1:0]   i_brightness;
    logic [ROWS-1:0]       o_rows;
    logic [COLS-1:0]       o_cols;
    logic                  o_frame_start;

    int n_tests = 0;
    int n_fail  = 0;

    led_matrix_scanner #(
        .ROWS           (ROWS),
        .COLS           (COLS),
        .ROW_DIV        (ROW_DIV),
        .BLANK          (BLANK),
        .PWM_BITS       (PWM_BITS),
        .ROW_ACTIVE_LOW (0),
        .COL_ACTIVE_LOW (1)
    ) dut (
        .i_clk         (clk),
        .i_reset       (i_reset),
        .i_data        (i_data),
        .i_load        (i_load),
        .o_load_ack    (o_load_ack),
        .i_brightness  (i_brightness),
        .o_rows        (o_rows),
        .o_cols        (o_cols),
        .o_frame_start (o_frame_start)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, " rows"}, 32'(o_rows), 32'h0);
        check({tag, " cols"}, 32'(o_cols), 32'hF);
        check({tag, " ack"}, 32'(o_load_ack), 32'h0);
        check({tag, " fs"}, 32'(o_frame_start), 32'h0);
    endtask

    // Called at the sample where o_frame_start is high; checks one full frame showing
    // 'disp' at brightness 'br', optionally issuing loads and a brightness change at
    // given sample indices, and ends on the next frame's first sample.
    task automatic scan_frame(input string name, input logic [15:0] disp, input int br,
                              input int la, input logic [15:0] da,
                              input int lb, input logic [15:0] db,
                              input int ba, input logic [1:0] bv);
        int row, slot, pwm;
        logic [3:0] nib, rexp, cexp;
        logic ack_exp;
        for (int k = 0; k < FRAME; k++) begin
            row  = k / ROW_DIV;
            slot = k % ROW_DIV;
            if (slot < BLANK) begin
                rexp = 4'h0;
                cexp = 4'hF;
            end else begin
                pwm  = (slot - BLANK) % 4;
                nib  = disp[row*4 +: 4];
                rexp = 4'(1 << row);
                cexp = (pwm < br) ? ~nib : 4'hF;
            end
            ack_exp = ((la >= 0) && (k == la + 1)) || ((lb >= 0) && (k == lb + 1));
            check($sformatf("%s k=%0d rows", name, k), 32'(o_rows), 32'(rexp));
            check($sformatf("%s k=%0d cols", name, k), 32'(o_cols), 32'(cexp));
            check($sformatf("%s k=%0d fs", name, k), 32'(o_frame_start), 32'(k == 0));
            check($sformatf("%s k=%0d ack", name, k), 32'(o_load_ack), 32'(ack_exp));
            i_load = 1'b0;
            if (k == la) begin
                i_load = 1'b1;
                i_data = da;
            end else if (k == lb) begin
                i_load = 1'b1;
                i_data = db;
            end
            if (k == ba) i_brightness = bv;
            tick();
        end
        check({name, " next_frame_start"}, 32'(o_frame_start), 32'h1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        i_reset      = 1'b1;
        i_load       = 1'b0;
        i_data       = '0;
        i_brightness = 2'd3;

        repeat (3) begin
            tick();
            check_idle("reset");
        end
        i_reset = 1'b0;
        check("release_c1 fs", 32'(o_frame_start), 32'h0);
        tick();

        // Dark first frame, 5A5A loaded immediately, shown from the next frame.
        scan_frame("f0", 16'h0000, 0, 0, 16'h5A5A, -1, '0, -1, '0);
        scan_frame("f1_5a5a", 16'h5A5A, 3, 10, 16'h0000, -1, '0, -1, '0);
        // All-lit load during row 2 must not tear the current frame.
        scan_frame("f2_tear", 16'h0000, 3, 45, 16'hFFFF, -1, '0, -1, '0);
        scan_frame("f3_lit", 16'hFFFF, 3, 5, 16'h000F, 30, 16'hF000, -1, '0);
        scan_frame("f4_latest", 16'hF000, 3, -1, '0, -1, '0, 10, 2'd0);
        // Brightness change mid-frame and a load on the boundary cycle itself.
        scan_frame("f5_dim0", 16'hF000, 0, 78, 16'h0F0F, -1, '0, 30, 2'd2);
        scan_frame("f6_bright2", 16'hF000, 2, -1, '0, -1, '0, -1, '0);

        // Frame 7 shows the boundary-cycle load; then reset mid-frame with a pending load.
        i_load = 1'b1;
        i_data = 16'h3C3C;
        tick();
        check("f7 ack", 32'(o_load_ack), 32'h1);
        i_load = 1'b0;
        tick();
        check("f7 row0 cols", 32'(o_cols), 32'h0);
        repeat (23) tick();
        check("f7 row1 rows", 32'(o_rows), 32'h2);

        i_reset = 1'b1;
        i_load  = 1'b1;
        tick();
        check_idle("midreset c1");
        i_load = 1'b0;
        repeat (2) begin
            tick();
            check_idle("midreset");
        end
        i_reset = 1'b0;
        check("midreset release fs", 32'(o_frame_start), 32'h0);
        tick();

        scan_frame("r1", 16'h0000, 0, -1, '0, -1, '0, -1, '0);
        scan_frame("r2", 16'h0000, 2, -1, '0, -1, '0, -1, '0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/led_matrix_scanner.md
LED_MATRIX_SCANNER -- requirements
Module: led_matrix_scanner

Interface
REQ-001 SHALL have parameter ROWS, default 8, number of matrix rows (>=2).
REQ-002 SHALL have parameter COLS, default 8, number of matrix columns (>=1).
REQ-003 SHALL have parameter ROW_DIV, default 8333, i_clk cycles per row slot (> BLANK + 2**PWM_BITS).
REQ-004 SHALL have parameter BLANK, default 16, anti-ghost blanking cycles at start of each row slot (>=1).
REQ-005 SHALL have parameter PWM_BITS, default 4, brightness width.
REQ-006 SHALL have parameter ROW_ACTIVE_LOW, default 0, 1 = selected row driven low.
REQ-007 SHALL have parameter COL_ACTIVE_LOW, default 1, 1 = lit column driven low.
REQ-008 SHALL have port i_clk  in  1  sole clock; all state on rising edge.
REQ-009 SHALL have port i_reset  in  1  synchronous, active-high reset.
REQ-010 SHALL have port i_data  in  ROWS*COLS  frame; bit r*COLS+c = pixel (row r, col c), 1 = lit.
REQ-011 SHALL have port i_load  in  1  capture i_data into pending buffer this cycle.
REQ-012 SHALL have port o_load_ack  out  1  one-cycle pulse, cycle after an accepted i_load.
REQ-013 SHALL have port i_brightness  in  PWM_BITS  global duty level, 0 = dark.
REQ-014 SHALL have port o_rows  out  ROWS  row select, one-hot in active polarity.
REQ-015 SHALL have port o_cols  out  COLS  column drive for selected row.
REQ-016 SHALL have port o_frame_start  out  1  one-cycle pulse at start of row-0 slot.

Function
REQ-017 SHALL keep slot counter 0..ROW_DIV-1, incrementing every cycle; at ROW_DIV-1 wraps to 0 and row index advances r -> r+1, ROWS-1 -> 0.
REQ-018 SHALL double-buffer: i_load=1 copies i_data to pending buffer and sets pending flag; every i_load accepted, acked next cycle.
REQ-019 SHALL, on multiple loads before a frame boundary, display only the last (latest wins).
REQ-020 SHALL, at frame boundary (row ROWS-1 -> 0 wrap), copy pending to display buffer if flag set, clear flag; i_load on that same cycle lands in pending for the next boundary (flag stays set).
REQ-021 SHALL sample i_brightness into bright_q at every frame boundary; brightness constant within a frame.
REQ-022 SHALL drive all rows and columns inactive while slot counter < BLANK.
REQ-023 SHALL, for slot counter >= BLANK, assert row r only, and column c active iff display[r*COLS+c]=1 and pwm_cnt < bright_q.
REQ-024 SHALL have pwm_cnt (PWM_BITS wide) = 0 at slot counter BLANK, incrementing each cycle, wrapping modulo 2**PWM_BITS.
REQ-025 SHALL register all outputs: state in cycle t appears on outputs in cycle t+1.
REQ-026 SHALL pulse o_frame_start for exactly one cycle per frame, in the cycle after row=0 and slot=0.
REQ-027 SHALL apply polarity parameters to o_rows/o_cols only; inactive level = active level inverted.
REQ-028 SHALL hold frame period at exactly ROWS*ROW_DIV cycles regardless of loads or brightness.

Reset
REQ-029 SHALL, while i_reset=1, clear row index, slot counter, pwm_cnt, display, pending, flag, bright_q to 0.
REQ-030 SHALL hold o_rows/o_cols at inactive levels, o_load_ack=0, o_frame_start=0 during reset.
REQ-031 SHALL discard any pending load on reset mid-frame; i_load during reset is ignored and not acked.
REQ-032 SHALL start row-0 slot on the first cycle after reset deasserts; o_frame_start pulses one cycle later.

Verification (ROWS=4, COLS=4, ROW_DIV=20, BLANK=2, PWM_BITS=2, ROW_ACTIVE_LOW=0, COL_ACTIVE_LOW=1)
REQ-033 SHALL test reset: i_reset 3 cycles -> o_rows=4'b0000, o_cols=4'b1111, acks/pulses 0; o_frame_start first high 2nd cycle after release.
REQ-034 SHALL test load+scan: i_data=16'h5A5A, i_brightness=3, one i_load -> ack next cycle; after next frame start rows 0001,0010,0100,1000 each 20 cycles; row0 cols 0101 inverted (1010) for pwm_cnt 0..2, 1111 at pwm_cnt 3 and in blank.
REQ-035 SHALL test tear-free: i_load 16'hFFFF in row 2 of displayed 16'h0000 -> rows 2,3 stay dark; all-lit from next frame start.
REQ-036 SHALL test latest-wins: loads 16'h000F then 16'hF000 in one frame -> two acks; next frame shows only row 3 lit.
REQ-037 SHALL test brightness: i_brightness=0 -> o_cols=1111 always; change to 2 mid-frame -> no effect until boundary, then lit 2 of every 4 active cycles.
REQ-038 SHALL test mid-frame reset: pending load, reset in row 1 -> after release display all dark, frame restarts at row 0, period 80 cycles.
